timed_data_memory: RTL and testbench

- Single-port synchronous data memory with a fixed 3-cycle access latency.
- A request is registered when `cs` is sampled high while the block is idle. Requests presented while an access is in flight are silently dropped, so an over-fast requester loses accesses.
- After reset the block fills its storage with a `fileid`-selected pattern before accepting requests.
- Sits between the CPU load/store stage and the data store.

---
 rtl/timed_data_memory_pkg.sv | 23 ++
 rtl/timed_data_memory_mem_array.sv | 25 ++
 rtl/timed_data_memory.sv | 106 ++++++++++
 tb/tb_timed_data_memory.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/timed_data_memory_pkg.sv
// Shared definitions for the timed data memory: controller states and the
// power-on image pattern.
package timed_data_memory_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        BUSY1,
        BUSY2
    } state_t;

    // Image word: fileid in the top nibble, index zero-extended below it.
    // Returned wide; the caller keeps the low dsize bits.
    function automatic logic [63:0] init_pattern(input logic [3:0] fid,
                                                 input int unsigned idx,
                                                 input int unsigned dsize);
        logic [63:0] w;
        w = 64'(idx) & ((64'd1 << (dsize - 4)) - 64'd1);
        w = w | (64'(fid) << (dsize - 4));
        return w;
    endfunction

endpackage

// File: rtl/timed_data_memory_mem_array.sv
// Single-port word array: synchronous write, combinational read.
module mem_array #(
    parameter int DSIZE      = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DSIZE-1:0]      wdata,
    output logic [DSIZE-1:0]      rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/timed_data_memory.sv
// Data memory with a fixed 3-cycle access latency; sweeps a fileid-selected
// image into storage after reset, then serves one access per three cycles.
module timed_data_memory
    import timed_data_memory_pkg::*;
#(
    parameter int ASIZE      = 16,
    parameter int DSIZE      = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             wen,
    input  logic [ASIZE-1:0] addr,
    input  logic [DSIZE-1:0] data_in,
    input  logic [3:0]       fileid,
    output logic [DSIZE-1:0] data_out
);

    state_t                state;
    logic [DEPTH_LOG2-1:0] init_cnt;
    logic [3:0]            fid_q;
    logic                  req_wen;
    logic [DEPTH_LOG2-1:0] req_addr;
    logic [DSIZE-1:0]      req_data;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [DSIZE-1:0]      mem_wdata;
    logic [DSIZE-1:0]      mem_rdata;
    logic [DSIZE-1:0]      init_word;

    // Upper address bits alias onto the decoded range.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ASIZE-1:DEPTH_LOG2];

    assign init_word = DSIZE'(init_pattern(fid_q, 32'(init_cnt), DSIZE));

    // The array port is shared between the init sweep and the access stage;
    // a reset edge suppresses any write so a pending store is never committed.
    always_comb begin
        mem_addr  = req_addr;
        mem_wdata = req_data;
        mem_we    = 1'b0;
        if (state == INIT) begin
            mem_addr  = init_cnt;
            mem_wdata = init_word;
            mem_we    = rst;
        end else if (state == BUSY2) begin
            mem_we    = rst & ~req_wen;
        end
    end

    mem_array #(
        .DSIZE      (DSIZE),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= INIT;
            init_cnt <= '0;
            data_out <= '0;
            fid_q    <= fileid;
            req_wen  <= 1'b1;
            req_addr <= '0;
            req_data <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (cs) begin
                        req_wen  <= wen;
                        req_addr <= addr[DEPTH_LOG2-1:0];
                        req_data <= data_in;
                        state    <= BUSY1;
                    end
                end
                BUSY1: begin
                    state <= BUSY2;
                end
                BUSY2: begin
                    if (req_wen) begin
                        data_out <= mem_rdata;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timed_data_memory.sv
// Scoreboard bench for timed_data_memory: expected words are queued when a
// request is driven and compared when the access completes.
module tb_timed_data_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs = 1'b0;
    logic        wen = 1'b1;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic [3:0]  fileid = '0;
    logic [15:0] data_out;

    int checks = 0;
    int failures = 0;

    logic [15:0] model_mem [256];
    logic [15:0] model_dout = '0;
    logic [15:0] sb [$];

    timed_data_memory #(
        .ASIZE      (16),
        .DSIZE      (16),
        .DEPTH_LOG2 (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .wen      (wen),
        .addr     (addr),
        .data_in  (data_in),
        .fileid   (fileid),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // One request; the result is checked just after E2.
    task automatic access(input logic is_write, input logic [15:0] a,
                          input logic [15:0] d, input string tag);
        logic [15:0] exp;
        @(negedge clk);
        cs = 1'b1; wen = ~is_write; addr = a; data_in = d;
        if (is_write) begin
            sb.push_back(model_dout);
            model_mem[a[7:0]] = d;
        end else begin
            sb.push_back(model_mem[a[7:0]]);
        end
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; addr = 16'($urandom); data_in = 16'($urandom); wen = 1'($urandom);
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, data_out=%h", tag, data_out);
        end else begin
            exp = sb.pop_front();
            if (data_out !== exp) begin
                failures++;
                $display("FAIL %s addr=%h: data_out=%h expected=%h", tag, a, data_out, exp);
            end
            if (!is_write) model_dout = exp;
        end
    endtask

    task automatic do_reset(input logic [3:0] fid, input logic hold_cs);
        @(negedge clk);
        rst = 1'b0; fileid = fid; cs = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_dout: data_out=%h expected=0000", data_out);
        end
        @(negedge clk);
        rst = 1'b1; fileid = ~fid; cs = hold_cs; wen = 1'b1; addr = '0;
        repeat (255) @(posedge clk);
        @(negedge clk);
        cs = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== 16'h0000) begin
            failures++;
            $display("FAIL init_dout: data_out=%h expected=0000", data_out);
        end
        for (int i = 0; i < 256; i++) model_mem[i] = {fid, 12'(i)};
        model_dout = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset(4'h0, 1'b0);
    endtask

    task automatic test_init_read();
        for (int i = 0; i < 20; i++) access(1'b0, 16'(i), '0, "init_read");
        access(1'b0, 16'h00FF, '0, "init_read_top");
        access(1'b0, 16'h0100, '0, "alias_read");
    endtask

    task automatic test_fileid();
        do_reset(4'hA, 1'b0);
        access(1'b0, 16'h0005, '0, "fileid_read");
        checks++;
        if (data_out !== 16'hA005) begin
            failures++;
            $display("FAIL fileid_const: data_out=%h expected=a005", data_out);
        end
    endtask

    task automatic test_write_readback();
        for (int i = 0; i < 20; i++) access(1'b1, 16'(i), 16'hFFFF - 16'(i), "write_hold");
        for (int i = 0; i < 20; i++) access(1'b0, 16'(i), '0, "readback");
        access(1'b1, 16'h0107, 16'h5A5A, "alias_write");
        access(1'b0, 16'h0007, '0, "alias_readback");
    endtask

    task automatic test_back_to_back_read();
        logic [15:0] exp;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            cs = (k < 20); wen = 1'b1; addr = 16'(k);
            @(posedge clk);
            #1;
            if (k < 20 && k % 3 == 0) sb.push_back(model_mem[k]);
            if (k % 3 == 2) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b2b_read: scoreboard empty at cycle %0d", k);
                end else begin
                    exp = sb.pop_front();
                    model_dout = exp;
                end
            end
            checks++;
            if (data_out !== model_dout) begin
                failures++;
                $display("FAIL b2b_read cycle=%0d: data_out=%h expected=%h", k, data_out, model_dout);
            end
        end
        cs = 1'b0;
    endtask

    task automatic test_back_to_back_write();
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            cs = (k < 20); wen = 1'b0; addr = 16'(k); data_in = 16'h00FF - 16'(k);
            if (k < 20 && k % 3 == 0) model_mem[k] = 16'h00FF - 16'(k);
            @(posedge clk);
            #1;
            checks++;
            if (data_out !== model_dout) begin
                failures++;
                $display("FAIL b2b_write_hold cycle=%0d: data_out=%h expected=%h", k, data_out, model_dout);
            end
        end
        cs = 1'b0; wen = 1'b1;
        for (int i = 0; i < 20; i++) access(1'b0, 16'(i), '0, "b2b_write_readback");
    endtask

    task automatic test_reset_in_busy();
        @(negedge clk);
        cs = 1'b1; wen = 1'b0; addr = 16'h0002; data_in = 16'h1234;
        @(posedge clk);
        do_reset(4'h3, 1'b1);
        access(1'b0, 16'h0002, '0, "abandoned_write");
        access(1'b0, 16'h0000, '0, "post_reset_read");
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_fileid();
        test_write_readback();
        test_back_to_back_read();
        test_back_to_back_write();
        test_reset_in_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
